// File: rtl/axi_regcfg_mem_slave.sv
// AXI4 slave memory model with a small register port for run-time control
// (enable, read latency) and burst/error counters. One burst per direction.
module axi_regcfg_mem_slave #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 6,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned RegAw        = 8,
  parameter int unsigned RegDw        = 32,
  parameter logic [AxiAddrWidth-1:0] MemBase  = 32'h8000_0000,
  parameter logic [AxiAddrWidth-1:0] MemBytes = 32'h0040_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [AxiIdWidth-1:0]     aw_id,
  input  logic [AxiAddrWidth-1:0]   aw_addr,
  input  logic [7:0]                aw_len,
  input  logic [2:0]                aw_size,
  input  logic [1:0]                aw_burst,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [AxiDataWidth-1:0]   w_data,
  input  logic [AxiDataWidth/8-1:0] w_strb,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [AxiIdWidth-1:0]     b_id,
  output logic [1:0]                b_resp,
  output logic [AxiUserWidth-1:0]   b_user,
  output logic                      b_valid,
  input  logic                      b_ready,
  input  logic [AxiIdWidth-1:0]     ar_id,
  input  logic [AxiAddrWidth-1:0]   ar_addr,
  input  logic [7:0]                ar_len,
  input  logic [2:0]                ar_size,
  input  logic [1:0]                ar_burst,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [AxiIdWidth-1:0]     r_id,
  output logic [AxiDataWidth-1:0]   r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic [AxiUserWidth-1:0]   r_user,
  output logic                      r_valid,
  input  logic                      r_ready,
  input  logic [RegAw-1:0]          reg_addr,
  input  logic                      reg_write,
  input  logic [RegDw-1:0]          reg_wdata,
  input  logic [RegDw/8-1:0]        reg_wstrb,
  input  logic                      reg_valid,
  output logic [RegDw-1:0]          reg_rdata,
  output logic                      reg_error,
  output logic                      reg_ready
);
  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MemBytes) - OffW;
  localparam int unsigned Words = 1 << IdxW;
  localparam logic [1:0]  DecErr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [AxiDataWidth-1:0] mem [Words];

  w_state_e w_state, w_state_d;
  r_state_e r_state, r_state_d;

  logic [AxiIdWidth-1:0]   w_id_q, r_id_q;
  logic [AxiAddrWidth-1:0] w_addr_q, r_addr_q, w_off, r_off;
  logic [2:0]              w_size_q, r_size_q;
  logic [1:0]              w_burst_q, r_burst_q;
  logic                    w_err_q;
  logic [7:0]              r_len_q, r_beat_q, lat_cnt;
  logic                    r_fresh;
  logic [AxiDataWidth-1:0] r_hold, r_word;
  logic                    ctrl_en;
  logic [7:0]              rd_lat;
  logic [31:0]             wr_cnt, rd_cnt, err_cnt;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    w_in_rng, r_in_rng;
  logic                    unused_sig;

  // Burst length on the write side is taken from w_last; upper reg bits have no storage.
  assign unused_sig = ^{aw_len, reg_wdata[RegDw-1:8], reg_wstrb[RegDw/8-1:1]};

  // FIXED holds the address; INCR and WRAP align down to size then step by 2^size.
  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] a,
                                                        input logic [2:0] sz, input logic [1:0] bt);
    logic [AxiAddrWidth-1:0] step;
    step = AxiAddrWidth'(1) << sz;
    if (bt == 2'b00) return a;
    return (a & ~(step - AxiAddrWidth'(1))) + step;
  endfunction

  assign w_off    = w_addr_q - MemBase;
  assign r_off    = r_addr_q - MemBase;
  assign w_in_rng = w_off < MemBytes;
  assign r_in_rng = r_off < MemBytes;
  assign r_word   = r_in_rng ? mem[r_off[OffW +: IdxW]] : '0;

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign b_hs  = b_valid & b_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign r_hs  = r_valid & r_ready;

  // Write FSM next state and handshake outputs; new bursts blocked while in reset.
  always_comb begin
    w_state_d = w_state;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_ready = ctrl_en & ~rst_n;
        if (aw_valid && ctrl_en && !rst_n) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_valid && w_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_id   = (w_state == W_RESP) ? w_id_q : '0;
  assign b_resp = (w_state == W_RESP && w_err_q) ? DecErr : 2'b00;
  assign b_user = '0;

  // Write burst state: latch AW, walk the address, remember any out-of-range beat.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      w_state <= W_IDLE; w_id_q <= '0; w_addr_q <= '0;
      w_size_q <= '0; w_burst_q <= '0; w_err_q <= 1'b0;
    end else begin
      w_state <= w_state_d;
      if (aw_hs) begin
        w_id_q <= aw_id; w_addr_q <= aw_addr; w_size_q <= aw_size;
        w_burst_q <= aw_burst; w_err_q <= 1'b0;
      end else if (w_hs) begin
        w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
        if (!w_in_rng) w_err_q <= 1'b1;
      end
    end
  end

  // Byte-strobed store; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_in_rng)
      for (int b = 0; b < StrbW; b++)
        if (w_strb[b]) mem[w_off[OffW +: IdxW]][b*8 +: 8] <= w_data[b*8 +: 8];
  end

  // Read FSM next state: optional latency wait, then beats until r_last is taken.
  always_comb begin
    r_state_d = r_state;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ar_ready = ctrl_en & ~rst_n;
        if (ar_valid && ctrl_en && !rst_n) r_state_d = (rd_lat == 8'd0) ? R_DATA : R_WAIT;
      end
      R_WAIT: if (lat_cnt == 8'd1) r_state_d = R_DATA;
      R_DATA: begin
        r_valid = 1'b1;
        if (r_ready && r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // First cycle of a beat shows memory live; later cycles replay the captured word
  // so data stays stable under backpressure even if the word is rewritten.
  assign r_data = (r_state == R_DATA) ? (r_fresh ? r_word : r_hold) : '0;
  assign r_resp = (r_state == R_DATA && !r_in_rng) ? DecErr : 2'b00;
  assign r_last = (r_state == R_DATA) && (r_beat_q == r_len_q);
  assign r_id   = (r_state == R_DATA) ? r_id_q : '0;
  assign r_user = '0;

  // Read burst state: latch AR, latency countdown, beat/address advance.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      r_state <= R_IDLE; r_id_q <= '0; r_addr_q <= '0; r_size_q <= '0;
      r_burst_q <= '0; r_len_q <= '0; r_beat_q <= '0; lat_cnt <= '0;
      r_fresh <= 1'b1; r_hold <= '0;
    end else begin
      r_state <= r_state_d;
      r_fresh <= (r_state != R_DATA) || r_hs;
      r_hold  <= r_data;
      if (ar_hs) begin
        r_id_q <= ar_id; r_addr_q <= ar_addr; r_size_q <= ar_size;
        r_burst_q <= ar_burst; r_len_q <= ar_len; r_beat_q <= '0; lat_cnt <= rd_lat;
      end else if (r_state == R_WAIT) begin
        lat_cnt <= lat_cnt - 8'd1;
      end else if (r_hs) begin
        r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q);
        r_beat_q <= r_beat_q + 8'd1;
      end
    end
  end

  // Control registers and completion/error counters.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      ctrl_en <= 1'b1; rd_lat <= '0; wr_cnt <= '0; rd_cnt <= '0; err_cnt <= '0;
    end else begin
      if (reg_valid && reg_write && reg_wstrb[0]) begin
        if (reg_addr == RegAw'(8'h00)) ctrl_en <= reg_wdata[0];
        if (reg_addr == RegAw'(8'h04)) rd_lat  <= reg_wdata[7:0];
      end
      wr_cnt  <= wr_cnt + 32'(b_hs);
      rd_cnt  <= rd_cnt + 32'(r_hs && r_last);
      err_cnt <= err_cnt + 32'(b_hs && w_err_q) + 32'(r_hs && r_last && !r_in_rng);
    end
  end

  // Combinational register read decode; unmapped offsets flag an error.
  always_comb begin
    reg_rdata = '0;
    reg_error = 1'b0;
    unique case (reg_addr)
      RegAw'(8'h00): reg_rdata = RegDw'(ctrl_en);
      RegAw'(8'h04): reg_rdata = RegDw'(rd_lat);
      RegAw'(8'h08): reg_rdata = RegDw'(wr_cnt);
      RegAw'(8'h0C): reg_rdata = RegDw'(rd_cnt);
      RegAw'(8'h10): reg_rdata = RegDw'(err_cnt);
      RegAw'(8'h14): reg_rdata = RegDw'(32'h4158_4D31);
      default:       reg_error = 1'b1;
    endcase
  end

  assign reg_ready = reg_valid & ~rst_n;

endmodule

// File: tb/tb_axi_regcfg_mem_slave.sv
// Scoreboard bench: tasks push expected B/R/register responses, a negedge
// monitor pops and compares whenever the DUT completes a handshake.
module tb_axi_regcfg_mem_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] WIN  = 32'h8000_2000;

  logic clk_i = 1'b0, rst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [5:0]  aw_id = '0, ar_id = '0, b_id, r_id;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic [7:0]  aw_len = '0, ar_len = '0, w_strb = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0, b_resp, r_resp;
  logic        aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready;
  logic        b_valid, b_ready = 1, ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 1;
  logic [0:0]  b_user, r_user;
  logic [63:0] w_data = '0, r_data;
  logic [7:0]  reg_addr = '0;
  logic        reg_write = 0, reg_valid = 0, reg_error, reg_ready;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic [3:0]  reg_wstrb = '0;

  axi_regcfg_mem_slave dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready),
    .reg_addr(reg_addr), .reg_write(reg_write), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_valid(reg_valid), .reg_rdata(reg_rdata), .reg_error(reg_error), .reg_ready(reg_ready)
  );

  typedef struct packed { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct packed { logic [31:0] data; logic err; } g_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  g_exp_t gq[$];
  logic [63:0] mdl [int unsigned];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int n_chk = 0, n_fail = 0, b_done = 0, r_done = 0;
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  bit bp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'h0040_0000;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o >> 3);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt);
    logic [31:0] st;
    st = 32'd1 << sz;
    if (bt == 2'b00) return a;
    return (a & ~(st - 32'd1)) + st;
  endfunction

  function automatic logic [63:0] mrd(input logic [31:0] a);
    if (!in_rng(a)) return 64'd0;
    if (mdl.exists(widx(a))) return mdl[widx(a)];
    return 64'd0;
  endfunction

  // Monitor: compare on every completed handshake.
  always @(negedge clk_i) begin
    if (!rst_n) begin
      if (b_valid && b_ready) begin
        if (bq.size() == 0) flag("b_unexpected");
        else begin
          b_exp_t e;
          e = bq.pop_front();
          chk("b_id", 64'(b_id), 64'(e.id));
          chk("b_resp", 64'(b_resp), 64'(e.resp));
          chk("b_user", 64'(b_user), 64'd0);
        end
        b_done++;
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) flag("r_unexpected");
        else begin
          r_exp_t e;
          e = rq.pop_front();
          chk("r_id", 64'(r_id), 64'(e.id));
          chk("r_data", r_data, e.data);
          chk("r_resp", 64'(r_resp), 64'(e.resp));
          chk("r_last", 64'(r_last), 64'(e.last));
          if (e.last) r_done++;
        end
      end
      if (reg_valid && reg_ready && !reg_write) begin
        if (gq.size() == 0) flag("reg_unexpected");
        else begin
          g_exp_t e;
          e = gq.pop_front();
          chk("reg_rdata", 64'(reg_rdata), 64'(e.data));
          chk("reg_error", 64'(reg_error), 64'(e.err));
        end
      end
    end
  end

  // Random B/R backpressure when enabled.
  always @(posedge clk_i) begin
    #1;
    b_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    r_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic reg_acc(input logic [7:0] a, input logic wr, input logic [31:0] d);
    @(posedge clk_i); #1;
    reg_addr = a; reg_write = wr; reg_wdata = d; reg_wstrb = 4'hF; reg_valid = 1'b1;
    @(posedge clk_i); #1;
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [31:0] d, input logic e);
    gq.push_back('{d, e});
    reg_acc(a, 1'b0, 32'd0);
  endtask

  task automatic axi_wr(input logic [5:0] id, input logic [31:0] a, input int len,
                        input logic [2:0] sz, input logic [1:0] bt);
    logic [31:0] ca;
    logic [63:0] w;
    bit err, hs;
    int tmo, bd;
    err = 0; ca = a;
    for (int i = 0; i <= len; i++) begin
      if (in_rng(ca)) begin
        w = mrd(ca);
        for (int b = 0; b < 8; b++) if (ws[i][b]) w[b*8 +: 8] = wd[i][b*8 +: 8];
        mdl[widx(ca)] = w;
      end else err = 1;
      ca = nxt(ca, sz, bt);
    end
    bq.push_back('{id, err ? 2'b11 : 2'b00});
    exp_wr++; if (err) exp_err++;
    bd = b_done;
    @(posedge clk_i); #1;
    aw_id = id; aw_addr = a; aw_len = 8'(len); aw_size = sz; aw_burst = bt; aw_valid = 1'b1;
    tmo = 0;
    do begin @(negedge clk_i); hs = aw_ready; @(posedge clk_i); #1; tmo++; end while (!hs && tmo < 200);
    aw_valid = 1'b0;
    if (!hs) flag("aw_timeout");
    for (int i = 0; i <= len; i++) begin
      w_data = wd[i]; w_strb = ws[i]; w_last = (i == len); w_valid = 1'b1;
      tmo = 0;
      do begin @(negedge clk_i); hs = w_ready; @(posedge clk_i); #1; tmo++; end while (!hs && tmo < 200);
      if (!hs) begin flag("w_timeout"); break; end
    end
    w_valid = 1'b0; w_last = 1'b0;
    tmo = 0;
    while (b_done == bd && tmo < 500) begin @(posedge clk_i); tmo++; end
    if (b_done == bd) flag("b_timeout");
  endtask

  task automatic axi_rd(input logic [5:0] id, input logic [31:0] a, input int len,
                        input logic [2:0] sz, input logic [1:0] bt, input bit wait_done);
    logic [31:0] ca;
    bit hs, ok;
    int tmo, rd;
    ca = a;
    for (int i = 0; i <= len; i++) begin
      ok = in_rng(ca);
      rq.push_back('{id, mrd(ca), ok ? 2'b00 : 2'b11, (i == len)});
      if (i == len) begin exp_rd++; if (!ok) exp_err++; end
      ca = nxt(ca, sz, bt);
    end
    rd = r_done;
    @(posedge clk_i); #1;
    ar_id = id; ar_addr = a; ar_len = 8'(len); ar_size = sz; ar_burst = bt; ar_valid = 1'b1;
    tmo = 0;
    do begin @(negedge clk_i); hs = ar_ready; @(posedge clk_i); #1; tmo++; end while (!hs && tmo < 200);
    ar_valid = 1'b0;
    if (!hs) flag("ar_timeout");
    if (wait_done) begin
      tmo = 0;
      while (r_done == rd && tmo < 2000) begin @(posedge clk_i); tmo++; end
      if (r_done == rd) flag("r_timeout");
    end
  endtask

  task automatic wait_rdone(input int target);
    int tmo;
    tmo = 0;
    while (r_done < target && tmo < 2000) begin @(posedge clk_i); tmo++; end
    if (r_done < target) flag("r_timeout");
  endtask

  initial begin
    int n, rd0, tmo;
    bit stall;
    logic [31:0] a;
    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready_valid", 64'({aw_ready, ar_ready, w_ready, b_valid, r_valid, reg_ready}), 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    chk("rst_b_resp", 64'({b_id, b_resp, r_id, r_resp}), 64'd0);
    #2 rst_n = 1'b0;

    reg_rd(8'h14, 32'h4158_4D31, 1'b0);
    reg_rd(8'h00, 32'd1, 1'b0);
    reg_rd(8'h04, 32'd0, 1'b0);
    reg_rd(8'hFC, 32'd0, 1'b1);
    reg_acc(8'h14, 1'b1, 32'hFFFF_FFFF);
    reg_rd(8'h14, 32'h4158_4D31, 1'b0);

    // Single beat write/read
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
    axi_wr(6'd5, BASE, 0, 3'd3, 2'b01);
    axi_rd(6'd9, BASE, 0, 3'd3, 2'b01, 1);
    reg_rd(8'h08, 32'd1, 1'b0);
    reg_rd(8'h0C, 32'd1, 1'b0);

    // INCR burst with a partial strobe on beat 2 over known contents
    for (int i = 0; i < 4; i++) begin wd[i] = {32'hAAAA_0000 + i, 32'h5555_0000 + i}; ws[i] = 8'hFF; end
    axi_wr(6'd1, BASE + 32'h100, 3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin wd[i] = {32'hC0DE_0000 + i, 32'hBEEF_0000 + i}; ws[i] = 8'hFF; end
    ws[2] = 8'h0F;
    axi_wr(6'd2, BASE + 32'h100, 3, 3'd3, 2'b01);
    axi_rd(6'd3, BASE + 32'h100, 3, 3'd3, 2'b01, 1);

    // Region boundaries
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF;
    axi_wr(6'd4, 32'h803F_FFF8, 0, 3'd3, 2'b01);
    wd[0] = 64'h1111_2222_3333_4444;
    axi_wr(6'd6, 32'h7FFF_FFF8, 0, 3'd3, 2'b01);
    axi_rd(6'd7, 32'h803F_FFF8, 0, 3'd3, 2'b01, 1);
    axi_rd(6'd8, 32'h8040_0000, 0, 3'd3, 2'b01, 1);
    reg_rd(8'h10, 32'd2, 1'b0);

    // Read latency
    reg_acc(8'h04, 1'b1, 32'd5);
    reg_rd(8'h04, 32'd5, 1'b0);
    rd0 = r_done;
    axi_rd(6'd10, BASE, 0, 3'd3, 2'b01, 0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!r_valid && n < 20);
    chk("rd_lat_cycles", 64'(n), 64'd6);
    wait_rdone(rd0 + 1);
    reg_acc(8'h04, 1'b1, 32'd0);

    // Enable gating
    reg_acc(8'h00, 1'b1, 32'd0);
    @(posedge clk_i); #1;
    aw_valid = 1'b1; ar_valid = 1'b1; aw_addr = BASE; ar_addr = BASE;
    stall = 0;
    repeat (8) begin @(negedge clk_i); if (aw_ready || ar_ready) stall = 1; end
    chk("ctrl_stall", 64'(stall), 64'd0);
    @(posedge clk_i); #1; aw_valid = 1'b0; ar_valid = 1'b0;
    reg_acc(8'h00, 1'b1, 32'd1);
    @(negedge clk_i);
    chk("ctrl_resume", 64'({aw_ready, ar_ready}), 64'd3);

    // Random traffic over an initialised window
    for (int i = 0; i < 64; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_wr(6'd11, WIN, 63, 3'd3, 2'b01);
    bp_en = 1;
    for (int k = 0; k < 200; k++) begin
      int len;
      logic [2:0] sz;
      logic [1:0] bt;
      len = $urandom_range(0, 7);
      sz = 3'($urandom_range(0, 3));
      bt = ($urandom_range(0, 3) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      a = WIN + $urandom_range(0, 440);
      if ($urandom_range(0, 15) == 0) a = a + 32'h1000_0000;
      for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      axi_wr(6'($urandom), a, len, sz, bt);
      len = $urandom_range(0, 7);
      sz = 3'($urandom_range(0, 3));
      bt = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      a = WIN + $urandom_range(0, 440);
      if ($urandom_range(0, 15) == 0) a = a + 32'h1000_0000;
      axi_rd(6'($urandom), a, len, sz, bt, 1);
    end
    bp_en = 0;
    @(posedge clk_i);
    reg_rd(8'h08, 32'(exp_wr), 1'b0);
    reg_rd(8'h0C, 32'(exp_rd), 1'b0);
    reg_rd(8'h10, 32'(exp_err), 1'b0);
    chk("queues_drained", 64'(bq.size() + rq.size() + gq.size()), 64'd0);

    // Reset in the middle of a read burst
    bp_en = 1;
    axi_rd(6'd12, WIN, 15, 3'd3, 2'b01, 0);
    tmo = 0;
    while (rq.size() > 10 && tmo < 500) begin @(posedge clk_i); tmo++; end
    if (rq.size() > 10) flag("mid_burst_timeout");
    @(posedge clk_i); #2;
    rst_n = 1'b1;
    #1;
    chk("rst_async_drop", 64'({r_valid, b_valid, aw_ready, ar_ready, w_ready}), 64'd0);
    chk("rst_async_data", r_data, 64'd0);
    rq.delete();
    bp_en = 0;
    repeat (3) @(posedge clk_i);
    #2 rst_n = 1'b0;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    reg_rd(8'h08, 32'd0, 1'b0);
    reg_rd(8'h0C, 32'd0, 1'b0);
    reg_rd(8'h00, 32'd1, 1'b0);
    axi_rd(6'd13, BASE, 0, 3'd3, 2'b01, 1);
    axi_rd(6'd14, WIN, 7, 3'd3, 2'b01, 1);
    reg_rd(8'h0C, 32'd2, 1'b0);
    chk("final_queues", 64'(bq.size() + rq.size() + gq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
